// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: N burst requesters share one FIFO write port, one tenure at a time.
// Latency: 1 cycle from an accepted beat to the registered fifowr/fifodin; one idle cycle per arbitration.
// Backpressure: a grant is given only while the FIFO has room, counting the in-flight write; flsh aborts.
module fifo_wr_arb #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int ADDR     = 4,
    parameter int MAXBURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] din,
    input  logic [NREQ-1:0]       last,
    output logic [NREQ-1:0]       gnt,
    input  logic                  flsh,
    input  logic [ADDR:0]         fifolen,
    output logic                  fifowr,
    output logic [WIDTH-1:0]      fifodin,
    output logic                  fifoflsh,
    output logic [2:0]            owner,
    output logic                  busy,
    output logic                  abort
);

    localparam int              LENGTH   = 1 << ADDR;
    localparam logic [ADDR+1:0] LENGTH_W = (ADDR+2)'(LENGTH);
    localparam logic [ADDR:0]   MAXB_W   = (ADDR+1)'(MAXBURST);
    localparam logic [3:0]      NREQ_W   = 4'(NREQ);
    localparam logic [2:0]      LAST_IDX = 3'(NREQ - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t           state_q, state_d;
    logic [2:0]       owner_q, owner_d;
    logic [2:0]       rr_ptr_q, rr_ptr_d;
    logic [ADDR:0]    cnt_q, cnt_d;
    logic             fifowr_q, fifowr_d;
    logic [WIDTH-1:0] fifodin_q, fifodin_d;
    logic             fifoflsh_q, fifoflsh_d;
    logic             abort_q, abort_d;

    logic             own_req;
    logic             own_last;
    logic [WIDTH-1:0] own_din;
    logic [ADDR+1:0]  occupancy;
    logic             space_ok;
    logic             accept;
    logic [2:0]       next_ptr;
    logic [ADDR:0]    cnt_inc;

    logic [2*NREQ-1:0] req_rot;
    logic [2:0]        arb_off;
    logic [3:0]        arb_sum;
    logic [2:0]        arb_idx;
    logic              arb_hit;

    // The write registered last cycle is not yet reflected in fifolen.
    assign occupancy = {1'b0, fifolen} + {{(ADDR+1){1'b0}}, fifowr_q};
    assign space_ok  = occupancy < LENGTH_W;
    assign next_ptr  = (owner_q == LAST_IDX) ? 3'd0 : owner_q + 3'd1;
    assign cnt_inc   = cnt_q + 1'b1;

    always_comb begin
        own_req  = 1'b0;
        own_last = 1'b0;
        own_din  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == 3'(i)) begin
                own_req  = req[i];
                own_last = last[i];
                own_din  = din[i*WIDTH +: WIDTH];
            end
        end
    end

    // Rotate so bit 0 is the requester at rr_ptr, then take the first set bit.
    always_comb begin
        req_rot = {req, req} >> rr_ptr_q;
        arb_off = '0;
        arb_hit = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                arb_off = 3'(i);
                arb_hit = 1'b1;
            end
        end
        arb_sum = {1'b0, rr_ptr_q} + {1'b0, arb_off};
        arb_idx = (arb_sum >= NREQ_W) ? 3'(arb_sum - NREQ_W) : arb_sum[2:0];
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        abort_d  = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!flsh && arb_hit) begin
                    state_d = XFER;
                    owner_d = arb_idx;
                    cnt_d   = '0;
                end
            end
            XFER: begin
                if (flsh || !own_req) begin
                    state_d  = IDLE;
                    abort_d  = 1'b1;
                    rr_ptr_d = next_ptr;
                end else if (space_ok) begin
                    accept = 1'b1;
                    cnt_d  = cnt_inc;
                    if (own_last || cnt_inc == MAXB_W) begin
                        state_d  = IDLE;
                        abort_d  = !own_last;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = accept && (owner_q == 3'(i));
        end
    end

    assign fifowr_d   = accept;
    assign fifodin_d  = accept ? own_din : fifodin_q;
    assign fifoflsh_d = flsh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            fifowr_q   <= 1'b0;
            fifodin_q  <= '0;
            fifoflsh_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            fifowr_q   <= fifowr_d;
            fifodin_q  <= fifodin_d;
            fifoflsh_q <= fifoflsh_d;
            abort_q    <= abort_d;
        end
    end

    assign fifowr   = fifowr_q;
    assign fifodin  = fifodin_q;
    assign fifoflsh = fifoflsh_q;
    assign owner    = owner_q;
    assign busy     = (state_q == XFER);
    assign abort    = abort_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb with default parameters (4 requesters, 8-bit data, depth 16, burst 4).
module tb_fifo_wr_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] din = '0;
    logic [3:0]  last = '0;
    logic        flsh = 1'b0;
    logic [4:0]  fifolen = '0;
    logic [3:0]  gnt;
    logic        fifowr;
    logic [7:0]  fifodin;
    logic        fifoflsh;
    logic [2:0]  owner;
    logic        busy;
    logic        abort;

    int checks = 0;
    int failures = 0;

    fifo_wr_arb #(.NREQ(4), .WIDTH(8), .ADDR(4), .MAXBURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .last(last), .gnt(gnt),
        .flsh(flsh), .fifolen(fifolen), .fifowr(fifowr), .fifodin(fifodin),
        .fifoflsh(fifoflsh), .owner(owner), .busy(busy), .abort(abort)
    );

    always #5 clk = ~clk;

    // Lane i carries {i, v} so the written byte identifies its source.
    function automatic logic [31:0] lanes(input logic [3:0] v);
        return {4'h3, v, 4'h2, v, 4'h1, v, 4'h0, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; req = '0; din = '0; last = '0; flsh = 1'b0; fifolen = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if ({fifowr, fifoflsh, abort} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {fifowr, fifoflsh, abort}); end
        checks++; if (fifodin !== 8'h00 || owner !== 3'd0) begin failures++; $display("FAIL reset_regs got=%h/%0d exp=00/0", fifodin, owner); end
    endtask

    task automatic test_alternate();
        logic [2:0] exp_own;
        logic [2:0] prev_own;
        reset_dut();
        prev_own = 3'd0;
        for (int t = 0; t < 4; t++) begin
            exp_own = (t % 2 == 1) ? 3'd2 : 3'd0;
            req = 4'b0101; last = 4'b0000; din = lanes(4'h0);
            #1;
            checks++; if (busy !== 1'b0 || gnt !== 4'b0000) begin failures++; $display("FAIL alt_idle t=%0d busy=%b gnt=%b exp=0/0000", t, busy, gnt); end
            if (t > 0) begin
                checks++; if (fifowr !== 1'b1 || fifodin !== {1'b0, prev_own, 4'(t*2-1)}) begin failures++; $display("FAIL alt_tail t=%0d wr=%b din=%h exp=1/%h", t, fifowr, fifodin, {1'b0, prev_own, 4'(t*2-1)}); end
                checks++; if (abort !== 1'b0) begin failures++; $display("FAIL alt_abort t=%0d got=%b exp=0", t, abort); end
            end
            tick();
            din = lanes(4'(t*2)); last = 4'b0000;
            #1;
            checks++; if (busy !== 1'b1 || owner !== exp_own) begin failures++; $display("FAIL alt_owner t=%0d busy=%b owner=%0d exp=1/%0d", t, busy, owner, exp_own); end
            checks++; if (gnt !== (4'b0001 << exp_own)) begin failures++; $display("FAIL alt_gnt1 t=%0d got=%b exp=%b", t, gnt, 4'b0001 << exp_own); end
            tick();
            din = lanes(4'(t*2+1)); last = 4'b1111;
            #1;
            checks++; if (gnt !== (4'b0001 << exp_own)) begin failures++; $display("FAIL alt_gnt2 t=%0d got=%b exp=%b", t, gnt, 4'b0001 << exp_own); end
            checks++; if (fifowr !== 1'b1 || fifodin !== {1'b0, exp_own, 4'(t*2)}) begin failures++; $display("FAIL alt_wr t=%0d wr=%b din=%h exp=1/%h", t, fifowr, fifodin, {1'b0, exp_own, 4'(t*2)}); end
            tick();
            prev_own = exp_own;
        end
        req = '0; last = '0;
        #1;
        checks++; if (fifowr !== 1'b1 || fifodin !== 8'h27) begin failures++; $display("FAIL alt_final wr=%b din=%h exp=1/27", fifowr, fifodin); end
    endtask

    task automatic test_maxburst();
        int ngnt;
        reset_dut();
        ngnt = 0;
        req = 4'b0010; last = 4'b0000;
        #1;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL mb_idle_gnt got=%b exp=0000", gnt); end
        tick();
        for (int i = 0; i < 4; i++) begin
            din = lanes(4'(i));
            #1;
            if (gnt == 4'b0010 && busy && owner == 3'd1) ngnt++;
            tick();
        end
        checks++; if (ngnt != 4) begin failures++; $display("FAIL mb_count got=%0d exp=4", ngnt); end
        checks++; if (abort !== 1'b1 || busy !== 1'b0 || gnt !== 4'b0000) begin failures++; $display("FAIL mb_abort abort=%b busy=%b gnt=%b exp=1/0/0000", abort, busy, gnt); end
        checks++; if (fifowr !== 1'b1 || fifodin !== 8'h13) begin failures++; $display("FAIL mb_lastwr wr=%b din=%h exp=1/13", fifowr, fifodin); end
        tick();
        checks++; if (busy !== 1'b1 || owner !== 3'd1 || abort !== 1'b0 || gnt !== 4'b0010) begin failures++; $display("FAIL mb_retenure busy=%b owner=%0d abort=%b gnt=%b exp=1/1/0/0010", busy, owner, abort, gnt); end
    endtask

    task automatic test_space();
        reset_dut();
        req = 4'b0001; fifolen = 5'd15;
        #1;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL sp_first got=%b exp=0001", gnt); end
        tick();
        fifolen = 5'd15;
        #1;
        checks++; if (fifowr !== 1'b1 || gnt !== 4'b0000) begin failures++; $display("FAIL sp_inflight wr=%b gnt=%b exp=1/0000", fifowr, gnt); end
        tick();
        fifolen = 5'd16;
        #1;
        checks++; if (gnt !== 4'b0000 || busy !== 1'b1 || abort !== 1'b0 || fifowr !== 1'b0) begin failures++; $display("FAIL sp_full gnt=%b busy=%b abort=%b wr=%b exp=0000/1/0/0", gnt, busy, abort, fifowr); end
        tick();
        fifolen = 5'd14;
        #1;
        checks++; if (gnt !== 4'b0001 || abort !== 1'b0) begin failures++; $display("FAIL sp_resume gnt=%b abort=%b exp=0001/0", gnt, abort); end
        tick();
        #1;
        checks++; if (gnt !== 4'b0001 || fifowr !== 1'b1) begin failures++; $display("FAIL sp_room gnt=%b wr=%b exp=0001/1", gnt, fifowr); end
    endtask

    task automatic test_flush();
        reset_dut();
        req = 4'b0011; din = lanes(4'h9);
        #1;
        tick();
        checks++; if (gnt !== 4'b0001 || owner !== 3'd0) begin failures++; $display("FAIL fl_start gnt=%b owner=%0d exp=0001/0", gnt, owner); end
        tick();
        flsh = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL fl_gnt got=%b exp=0000", gnt); end
        tick();
        flsh = 1'b0;
        #1;
        checks++; if ({fifoflsh, fifowr, abort, busy} !== 4'b1010) begin failures++; $display("FAIL fl_after flsh/wr/abort/busy=%b exp=1010", {fifoflsh, fifowr, abort, busy}); end
        tick();
        checks++; if (busy !== 1'b1 || owner !== 3'd1 || fifoflsh !== 1'b0 || abort !== 1'b0) begin failures++; $display("FAIL fl_next busy=%b owner=%0d flsh=%b abort=%b exp=1/1/0/0", busy, owner, fifoflsh, abort); end
    endtask

    task automatic test_req_drop();
        reset_dut();
        req = 4'b0100;
        #1;
        tick();
        checks++; if (gnt !== 4'b0100 || owner !== 3'd2) begin failures++; $display("FAIL rd_gnt1 gnt=%b owner=%0d exp=0100/2", gnt, owner); end
        tick();
        req = 4'b0000;
        #1;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rd_drop got=%b exp=0000", gnt); end
        tick();
        req = 4'b0100;
        #1;
        checks++; if ({abort, busy, fifowr, gnt[2]} !== 4'b1000) begin failures++; $display("FAIL rd_abort abort/busy/wr/gnt2=%b exp=1000", {abort, busy, fifowr, gnt[2]}); end
        tick();
        checks++; if (busy !== 1'b1 || gnt !== 4'b0100 || abort !== 1'b0) begin failures++; $display("FAIL rd_rearb busy=%b gnt=%b abort=%b exp=1/0100/0", busy, gnt, abort); end
    endtask

    task automatic test_async_reset();
        reset_dut();
        req = 4'b0001; din = lanes(4'h5);
        #1;
        tick();
        tick();
        checks++; if (fifowr !== 1'b1 || gnt !== 4'b0001) begin failures++; $display("FAIL ar_pre wr=%b gnt=%b exp=1/0001", fifowr, gnt); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({gnt, busy, fifowr, fifoflsh, abort} !== 8'h00 || fifodin !== 8'h00 || owner !== 3'd0) begin failures++; $display("FAIL ar_now gnt=%b busy=%b wr=%b flsh=%b abort=%b din=%h owner=%0d exp=all 0", gnt, busy, fifowr, fifoflsh, abort, fifodin, owner); end
        tick();
        tick();
        rst = 1'b0; req = 4'b1010;
        #1;
        checks++; if (fifowr !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000) begin failures++; $display("FAIL ar_post wr=%b busy=%b gnt=%b exp=0/0/0000", fifowr, busy, gnt); end
        tick();
        checks++; if (busy !== 1'b1 || owner !== 3'd1 || fifowr !== 1'b0 || gnt !== 4'b0010) begin failures++; $display("FAIL ar_first busy=%b owner=%0d wr=%b gnt=%b exp=1/1/0/0010", busy, owner, fifowr, gnt); end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_maxburst();
        test_space();
        test_flush();
        test_req_drop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
